// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and byte-enable helper for dmem_ctrl
package dmem_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int LANES = 8;
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
    return m[LANES-1:0];
  endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store request and response bus of dmem_ctrl
// DMEM_SIGNEXT_EN adds req_signed for sign-extending loads
interface dmem_if #(parameter int DATA_W = 64, parameter int ADDR_W = 64);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef DMEM_SIGNEXT_EN
  logic              req_signed;
`endif
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err_align;
  logic              rsp_err_range;
  logic              busy;
  modport master (
`ifdef DMEM_SIGNEXT_EN
    output req_signed,
`endif
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err_align, rsp_err_range, busy
  );
  modport slave (
`ifdef DMEM_SIGNEXT_EN
    input  req_signed,
`endif
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err_align, rsp_err_range, busy
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian store lane placement and load extraction/extension
module dmem_lane_align import dmem_pkg::*; #(parameter int DATA_W = 64) (
  input  logic [1:0]        i_size,
  input  logic [2:0]        i_off,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rword,
  output logic [DATA_W-1:0] o_wword,
  output logic [DATA_W-1:0] o_wbits,
  output logic [DATA_W-1:0] o_rdata
);
  logic [LANES-1:0]  w_lanes;
  logic [5:0]        w_sh;
  logic [DATA_W-1:0] w_shift;
  always_comb begin
    w_lanes = lane_mask(i_size, i_off);
    w_sh = {i_off, 3'b000};
    for (int i = 0; i < LANES; i++) o_wbits[i*8 +: 8] = {8{w_lanes[i]}};
    o_wword = i_wdata << w_sh;
    w_shift = i_rword >> w_sh;
    o_rdata = i_size == SZ_B ? {{(DATA_W-8){i_signed & w_shift[7]}}, w_shift[7:0]}
            : i_size == SZ_H ? {{(DATA_W-16){i_signed & w_shift[15]}}, w_shift[15:0]}
            : i_size == SZ_W ? {{(DATA_W-32){i_signed & w_shift[31]}}, w_shift[31:0]}
            : w_shift;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: fixed-latency load/store data memory controller with align/range checks
// DMEM_SIGNEXT_EN enables sign-extending loads via req_signed
module dmem_ctrl import dmem_pkg::*; #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  state_t            r_state, w_next;
  logic [2:0]        r_cnt, w_cnt;
  logic              r_write;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid, r_err_align, r_err_range;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_acc, w_ealign, w_erange, w_ok, w_signed;
  logic [IW-1:0]     w_idx;
  logic [DATA_W-1:0] w_wword, w_wbits, w_rdata;
  assign bus.req_ready     = r_state == IDLE || r_state == RESP;
  assign bus.busy          = r_state == WAIT || (r_state == RESP && !bus.req_valid) ||
                             (r_state == IDLE && bus.req_valid && LATENCY > 1);
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_rdata     = r_rdata;
  assign bus.rsp_err_align = r_err_align;
  assign bus.rsp_err_range = r_err_range;
  assign w_acc    = bus.req_valid && bus.req_ready;
  assign w_idx    = r_addr[IW+2:3];
  assign w_erange = |r_addr[ADDR_W-1:IW+3];
  assign w_ealign = |(r_addr[2:0] & ((3'd1 << r_size) - 3'd1));
  assign w_ok     = r_state == RESP && !w_ealign && !w_erange;
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    if (r_state == WAIT) begin
      w_cnt  = r_cnt - 3'd1;
      w_next = r_cnt == 3'd1 ? RESP : WAIT;
    end else if (w_acc) begin
      w_next = LATENCY == 1 ? RESP : WAIT;
      w_cnt  = 3'(LATENCY - 1);
    end else if (r_state == RESP) begin
      w_next = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err_align <= 1'b0;
      r_err_range <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_rsp_valid <= r_state == RESP;
      r_err_align <= r_state == RESP && w_ealign;
      r_err_range <= r_state == RESP && w_erange;
      r_rdata     <= w_ok && !r_write ? w_rdata : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_write <= bus.req_write;
      r_size  <= bus.req_size;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end
`ifdef DMEM_SIGNEXT_EN
  logic r_signed;
  always_ff @(posedge clk) if (w_acc) r_signed <= bus.req_signed;
  assign w_signed = r_signed;
`else
  assign w_signed = 1'b0;
`endif
  // The array is touched only in the response-forming edge, so an in-flight request dropped by reset never writes
  always_ff @(posedge clk) if (w_ok && r_write) r_mem[w_idx] <= (r_mem[w_idx] & ~w_wbits) | (w_wword & w_wbits);
  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_size  (r_size),
    .i_off   (r_addr[2:0]),
    .i_signed(w_signed),
    .i_wdata (r_wdata),
    .i_rword (r_mem[w_idx]),
    .o_wword (w_wword),
    .o_wbits (w_wbits),
    .o_rdata (w_rdata)
  );
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench with a byte-array reference model
module tb_dmem_ctrl;
  localparam int LAT = 2;
  localparam int DEPTH = 128;
  typedef struct {
    longint unsigned due;
    logic [63:0]     d;
    logic            ea;
    logic            er;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  longint unsigned cyc = 0;
  int ncmp = 0;
  int nfail = 0;
  int lowrun = 0;
  exp_t q[$];
  logic [7:0] mm [0:8*DEPTH-1];
  logic [63:0] last_d;
  logic last_ea, last_er;
  dmem_if #(.DATA_W(64), .ADDR_W(64)) bus();
  dmem_ctrl #(.DATA_W(64), .ADDR_W(64), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  function automatic exp_t model(input logic w, input logic [1:0] sz, input logic [63:0] a,
                                 input logic [63:0] wd, input logic sg, input longint unsigned due);
    exp_t e;
    int n;
    n = 1 << sz;
    e.due = due;
    e.ea = (a % n) != 0;
    e.er = a >= 64'(8 * DEPTH);
    e.d = '0;
    if (!e.ea && !e.er) begin
      if (w) begin
        for (int i = 0; i < n; i++) mm[int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) e.d[8*i +: 8] = mm[int'(a) + i];
        if (sg && n < 8 && e.d[8*n-1]) for (int i = n; i < 8; i++) e.d[8*i +: 8] = 8'hFF;
      end
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due == cyc) begin
      chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("rsp_rdata", bus.rsp_rdata, q[0].d);
      chk("rsp_err_align", 64'(bus.rsp_err_align), 64'(q[0].ea));
      chk("rsp_err_range", 64'(bus.rsp_err_range), 64'(q[0].er));
      last_d = bus.rsp_rdata;
      last_ea = bus.rsp_err_align;
      last_er = bus.rsp_err_range;
      void'(q.pop_front());
    end else begin
      chk("rsp_idle", 64'(bus.rsp_valid), 64'd0);
    end
    if (!reset) begin
      lowrun = bus.req_ready ? 0 : lowrun + 1;
      chk("ready_low_run", 64'(lowrun > LAT - 1), 64'd0);
    end
  end
  task automatic drive(input logic w, input logic [1:0] sz, input logic [63:0] a,
                       input logic [63:0] wd, input logic sg);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
`ifdef DMEM_SIGNEXT_EN
    bus.req_signed = sg;
`endif
  endtask
  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 64'd0, 64'd1);
  endtask
  task automatic req(input logic w, input logic [1:0] sz, input logic [63:0] a,
                     input logic [63:0] wd, input logic sg);
    logic ok, s;
    @(negedge clk);
    drive(w, sz, a, wd, sg);
    wait_ready(ok);
    if (ok) begin
`ifdef DMEM_SIGNEXT_EN
      s = sg;
`else
      s = 1'b0;
`endif
      q.push_back(model(w, sz, a, wd, s, cyc + 1 + LAT));
      @(posedge clk);
    end
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      chk("rsp_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask
  task automatic load_lit(input string nm, input logic [1:0] sz, input logic [63:0] a, input logic sg,
                          input logic [63:0] exp, input logic ea, input logic er);
    req(1'b0, sz, a, '0, sg);
    wait_idle();
    chk({nm, "_data"}, last_d, exp);
    chk({nm, "_flags"}, {62'd0, last_ea, last_er}, {62'd0, ea, er});
  endtask
  initial begin
    logic ok;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef DMEM_SIGNEXT_EN
    bus.req_signed = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_rdata", bus.rsp_rdata, 64'd0);
    chk("reset_flags", {62'd0, bus.rsp_err_align, bus.rsp_err_range}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    drive(1'b1, 2'd3, 64'h10, 64'h1122334455667788, 1'b0);
    #1 chk("busy_accept_cycle", 64'(bus.busy), 64'd1);
    bus.req_valid = 1'b0;
    req(1'b1, 2'd3, 64'h10, 64'h1122334455667788, 1'b0);
    wait_idle();
    chk("store_d_flags", {62'd0, last_ea, last_er}, 64'd0);
    load_lit("load_d", 2'd3, 64'h10, 1'b0, 64'h1122334455667788, 1'b0, 1'b0);
    req(1'b1, 2'd0, 64'h13, 64'hAB, 1'b0);
    load_lit("load_d_after_b", 2'd3, 64'h10, 1'b0, 64'h11223344AB667788, 1'b0, 1'b0);
    load_lit("load_h", 2'd1, 64'h12, 1'b0, 64'h000000000000AB66, 1'b0, 1'b0);
    req(1'b1, 2'd3, 64'h30, 64'hCAFEF00D12345678, 1'b0);
    req(1'b1, 2'd3, 64'h20, 64'h0123456789ABCDEF, 1'b0);
    load_lit("b2b_load", 2'd3, 64'h20, 1'b0, 64'h0123456789ABCDEF, 1'b0, 1'b0);
    req(1'b1, 2'd2, 64'h24, 64'hDEADBEEF, 1'b0);
    req(1'b0, 2'd2, 64'h24, '0, 1'b0);
    load_lit("b2b_word", 2'd3, 64'h20, 1'b0, 64'hDEADBEEF89ABCDEF, 1'b0, 1'b0);
    load_lit("misalign_h", 2'd1, 64'h11, 1'b0, 64'd0, 1'b1, 1'b0);
    load_lit("range_d", 2'd3, 64'(8 * DEPTH), 1'b0, 64'd0, 1'b0, 1'b1);
    load_lit("both_err", 2'd3, 64'(8 * DEPTH + 1), 1'b0, 64'd0, 1'b1, 1'b1);
    load_lit("range_hi_bit", 2'd3, 64'h8000000000000010, 1'b0, 64'd0, 1'b0, 1'b1);
    req(1'b1, 2'd2, 64'h12, 64'hFFFFFFFF, 1'b0);
    req(1'b1, 2'd3, 64'h8000000000000010, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    load_lit("unchanged", 2'd3, 64'h10, 1'b0, 64'h11223344AB667788, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'd3, 64'h30, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    wait_ready(ok);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    load_lit("after_abort", 2'd3, 64'h30, 1'b0, 64'hCAFEF00D12345678, 1'b0, 1'b0);
    req(1'b1, 2'd3, 64'h40, 64'h0, 1'b0);
    req(1'b1, 2'd0, 64'h40, 64'h80, 1'b0);
    load_lit("load_b_unsigned", 2'd0, 64'h40, 1'b0, 64'h80, 1'b0, 1'b0);
`ifdef DMEM_SIGNEXT_EN
    load_lit("load_b_signed", 2'd0, 64'h40, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0, 1'b0);
    load_lit("load_h_signed", 2'd1, 64'h40, 1'b1, 64'h80, 1'b0, 1'b0);
`else
    load_lit("load_b_nosign", 2'd0, 64'h40, 1'b1, 64'h80, 1'b0, 1'b0);
`endif
    repeat (3) @(negedge clk);
    chk("final_busy", 64'(bus.busy), 64'd0);
    chk("final_ready", 64'(bus.req_ready), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, multi-cycle data-memory controller for the pipelined LEGv8 core; replaces the single-cycle combinational Data_Memory.
- Accepts one load/store per handshake and returns the result after a fixed, configurable latency.
- Supports byte/half/word/double access sizes, little-endian.
- Flags misaligned and out-of-range accesses so the core can stall and trap.

Parameters:
- DATA_W, 64, data width in bits; fixed at 64 for LEGv8, parametrised for reuse.
- ADDR_W, 64, byte-address width.
- DEPTH, 128, number of DATA_W-bit words in the array; power of 2.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  load data, right-aligned and zero-extended; 0 for stores and errors.
- rsp_err_align  out  1  with rsp_valid: address not aligned to the access size.
- rsp_err_range  out  1  with rsp_valid: word index >= DEPTH.
- busy  out  1  request in flight; drives pipeline stall.

Behaviour:
- Reset values: state IDLE, counter 0, req_ready 1, rsp_valid 0, rsp_rdata 0, both error flags 0, busy 0. Array contents are not reset.
- Reset asserted mid-operation: the in-flight request is dropped, no array write occurs, and no response is issued.
- FSM has three states: IDLE, WAIT, RESP.
- Acceptance: a request is accepted at a rising edge where req_valid && req_ready. req_ready = (state == IDLE) || (state == RESP).
- On acceptance the controller latches write, size, address and wdata.
  - If LATENCY == 1, go to RESP.
  - Otherwise go to WAIT with counter = LATENCY-1.
- WAIT: the counter decrements each edge; at the edge where the counter reaches 1, go to RESP.
- Timing: for acceptance at edge t0, rsp_valid is high for exactly the cycle following edge t0+LATENCY.
- Array write/read timing: the array write (store) and the array read (load) happen at edge t0+LATENCY. A load accepted during a store's RESP cycle therefore sees the stored data.
- RESP with req_valid: accept the new request (back-to-back). Throughput is one request per LATENCY cycles.
- RESP without req_valid: return to IDLE.
- busy = (state == WAIT) || (state == RESP && !req_valid) || (state == IDLE && req_valid && LATENCY > 1). The last term is registered-independent, so the core stalls in the acceptance cycle.
- Word index = req_addr[log2(DEPTH)+2 : 3]. Any set address bit above that field, or an index >= DEPTH, gives err_range.
- Alignment: misaligned if the low req_size bits of the address are nonzero.
- Error handling: on any error there is no array access and rdata is 0. Both flags may assert together.
- Stores update only the addressed byte lanes (lane = addr[2:0]). Other lanes are preserved.
- Loads return the selected lanes shifted to bit 0, upper bits zero.

Optional Feature:
- Macro: DMEM_SIGNEXT_EN.
- When defined:
  - Adds input port req_signed (1 bit), latched on acceptance.
  - Loads with req_signed = 1 sign-extend the loaded value from its size (LDURSB/LDURSH/LDURSW).
  - Stores ignore req_signed.
- When undefined: the port is absent and all loads are zero-extended.

Decomposition:
- Shared package dmem_pkg holds:
  - Size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - State enum IDLE/WAIT/RESP.
  - Function lane_mask(size, addr[2:0]) returning an 8-bit byte-enable.
- One natural sub-module: dmem_lane_align (combinational). It handles write-data lane shifting/masking and read-data extraction/extension. dmem_ctrl holds the FSM, counter and array.

Test Plan:
- Reset, LATENCY=2: store double 0x1122334455667788 to addr 0x10 at t0 -> rsp_valid at t0+2 with no errors. Load double from 0x10 -> rdata 0x1122334455667788.
- Byte store 0xAB to 0x13 over the previous value, then double load from 0x10 -> 0x11223344AB667788. Half load from 0x12 -> 0x000000000000AB66.
- Back-to-back: store to 0x20 then load from 0x20, with the load issued in the store's RESP cycle -> load returns the new data. req_ready is never low for more than LATENCY-1 consecutive cycles.
- Half load from 0x11 -> rsp_err_align=1, rdata 0. Double load from 8*DEPTH -> rsp_err_range=1. Array is unchanged afterwards.
- Reset pulse one cycle after accepting a store to 0x30 -> no rsp_valid. A following load from 0x30 returns the prior contents.
- With DMEM_SIGNEXT_EN defined: store byte 0x80 at 0x40, then signed byte load -> 0xFFFFFFFFFFFFFF80. Unsigned byte load -> 0x80.
